// File: rtl/title_pixel_fetch.sv
// Title-screen pixel fetch: sprite ROM address stage, latency-matched valid chain,
// 16-entry palette and fade-in level scaling. Fade FSM is built only with TITLE_FADE_EN.
module title_pixel_fetch (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [16:0] title_address,
  input  logic        is_title,
  input  logic        frame_start,
  input  logic        fade_restart,
  output logic [16:0] rom_addr,
  output logic        rom_rd,
  input  logic [3:0]  rom_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [23:0] pal_rgb,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        pix_valid,
  output logic [1:0]  fade_state,
  output logic [4:0]  fade_level
);

  // Streaming pipeline with no backpressure: one pixel accepted and one produced
  // every cycle; rom_rd acts as the valid qualifier for the ROM request.
  logic [1:0]  vld_sr;
  logic [23:0] pal [16];
  logic [4:0]  level;
  logic        opaque;
  logic [23:0] lut_rgb;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] lv);
    logic [11:0] p;
    p = 12'(c) * 12'(lv);
    return p[11:4];
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      rom_rd   <= 1'b0;
    end else begin
      rom_rd   <= is_title;
      rom_addr <= is_title ? title_address : 17'd0;
    end
  end

  // rom_rd plus these two bits form the 3-deep chain; vld_sr[1] lines up with rom_data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vld_sr <= '0;
    else       vld_sr <= {vld_sr[0], rom_rd};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  assign opaque  = vld_sr[1] && (rom_data != 4'd0);
  assign lut_rgb = pal[rom_data];

  // The lookup reads the pre-edge palette, so a same-cycle write is seen one cycle later.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      pix_valid <= 1'b0;
    end else if (opaque) begin
      Red       <= scale(lut_rgb[23:16], level);
      Green     <= scale(lut_rgb[15:8], level);
      Blue      <= scale(lut_rgb[7:0], level);
      pix_valid <= 1'b1;
    end else begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      pix_valid <= 1'b0;
    end
  end

`ifdef TITLE_FADE_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FADE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0] state;
  logic [1:0] frame_cnt;

  // The entering frame_start already counts, so level steps on every 4th frame_start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      level     <= '0;
    end else if (fade_restart) begin
      state     <= ST_FADE;
      frame_cnt <= '0;
      level     <= '0;
    end else if (frame_start) begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FADE;
          frame_cnt <= frame_cnt + 2'd1;
        end
        ST_FADE: begin
          frame_cnt <= frame_cnt + 2'd1;
          if (frame_cnt == 2'd3) begin
            level <= level + 5'd1;
            if (level == 5'd15) state <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_HOLD;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fade_state = state;
`else
  logic unused_fade_inputs;

  assign unused_fade_inputs = frame_start ^ fade_restart;
  assign level              = 5'd16;
  // Without the fade feature the block reports itself permanently in HOLD.
  assign fade_state         = 2'd2;
`endif

  assign fade_level = level;

endmodule

// File: tb/tb_title_pixel_fetch.sv
// Bench for title_pixel_fetch: directed vector table, fade and reset sequences,
// and random traffic against a delay-line / palette / frame-count reference model.
module tb_title_pixel_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [16:0] title_address = '0;
  logic        is_title = 1'b0;
  logic        frame_start = 1'b0;
  logic        fade_restart = 1'b0;
  logic [16:0] rom_addr;
  logic        rom_rd;
  logic [3:0]  rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_rgb = '0;
  logic [7:0]  Red, Green, Blue;
  logic        pix_valid;
  logic [1:0]  fade_state;
  logic [4:0]  fade_level;

  int total = 0;
  int bad = 0;

  title_pixel_fetch dut (
    .Clk(Clk), .Reset(Reset), .title_address(title_address), .is_title(is_title),
    .frame_start(frame_start), .fade_restart(fade_restart), .rom_addr(rom_addr),
    .rom_rd(rom_rd), .rom_data(rom_data), .pal_we(pal_we), .pal_idx(pal_idx),
    .pal_rgb(pal_rgb), .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid),
    .fade_state(fade_state), .fade_level(fade_level)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // Sprite ROM: data = low nibble of the address, two cycles after the read cycle;
  // junk when no read was issued.
  logic [16:0] rom_a1;
  logic        rom_r1;
  always @(posedge Clk) begin
    rom_r1   <= rom_rd;
    rom_a1   <= rom_addr;
    rom_data <= rom_r1 ? rom_a1[3:0] : 4'($urandom);
  end

  // reference model
  logic [23:0] m_pal [16];
  int          m_line[$];
  logic [24:0] exp_q[$];
  int          m_n;
  bit          m_active;

  function automatic int m_level();
`ifdef TITLE_FADE_EN
    if (!m_active) return 0;
    return (m_n / 4 > 16) ? 16 : m_n / 4;
`else
    return 16;
`endif
  endfunction

  function automatic int m_state();
    if (!m_active) return 0;
    return (m_n >= 64) ? 2 : 1;
  endfunction

  function automatic logic [24:0] m_pixel(input int idx);
    logic [23:0] c;
    int l, r, g, b;
    if (idx <= 0) return 25'd0;
    c = m_pal[idx];
    l = m_level();
    r = (int'(c[23:16]) * l) >> 4;
    g = (int'(c[15:8]) * l) >> 4;
    b = (int'(c[7:0]) * l) >> 4;
    return {1'b1, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    m_line.delete();
    repeat (3) m_line.push_back(-1);
    exp_q.delete();
    m_n = 0;
    m_active = 0;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver: one pixel cycle, model step, compare after the edge
  task automatic cycle(input bit t, input logic [16:0] a, input bit we, input logic [3:0] wi,
                       input logic [23:0] wd, input bit fs, input bit fr);
    logic [24:0] e;
    is_title = t; title_address = a; pal_we = we; pal_idx = wi; pal_rgb = wd;
    frame_start = fs; fade_restart = fr;
    m_line.push_back(t ? int'(a[3:0]) : -1);
    exp_q.push_back(m_pixel(m_line.pop_front()));
    if (we) m_pal[wi] = wd;
    if (fr) begin
      m_active = 1; m_n = 0;
    end else if (fs) begin
      m_active = 1;
      if (m_n < 64) m_n++;
    end
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk("pixel", {7'd0, pix_valid, Red, Green, Blue}, {7'd0, e});
    chk("rom_rd", {31'd0, rom_rd}, {31'd0, t});
    chk("rom_addr", {15'd0, rom_addr}, t ? {15'd0, a} : 32'd0);
    chk("level", {27'd0, fade_level}, 32'(m_level()));
`ifdef TITLE_FADE_EN
    chk("state", {30'd0, fade_state}, 32'(m_state()));
`endif
  endtask

  task automatic idle(input int n, input bit fs);
    for (int i = 0; i < n; i++) cycle(0, 17'd0, 0, 4'd0, 24'd0, fs, 0);
  endtask

  // asynchronous reset: outputs must drop before any clock edge
  task automatic do_reset();
    Reset = 1'b1;
    is_title = 0; title_address = '0; pal_we = 0; frame_start = 0; fade_restart = 0;
    #1;
    chk("rst_pixel", {7'd0, pix_valid, Red, Green, Blue}, 32'd0);
    chk("rst_rom_rd", {31'd0, rom_rd}, 32'd0);
    chk("rst_rom_addr", {15'd0, rom_addr}, 32'd0);
`ifdef TITLE_FADE_EN
    chk("rst_level", {27'd0, fade_level}, 32'd0);
    chk("rst_state", {30'd0, fade_state}, 32'd0);
`endif
    repeat (2) @(posedge Clk);
    #3;
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          t;
    logic [16:0] a;
    bit          we;
    logic [3:0]  wi;
    logic [23:0] wd;
    logic [24:0] exp_pix;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{0, 17'h00000, 1, 4'd5, 24'hFF8000, 25'h0};
    tbl[1]  = '{0, 17'h00000, 1, 4'd3, 24'h123456, 25'h0};
    tbl[2]  = '{1, 17'h00005, 0, 4'd0, 24'h0,      25'h0};
    tbl[3]  = '{1, 17'h00000, 0, 4'd0, 24'h0,      25'h0};
    tbl[4]  = '{1, 17'h00003, 0, 4'd0, 24'h0,      25'h0};
    tbl[5]  = '{0, 17'h1ABC3, 0, 4'd0, 24'h0,      {1'b1, 24'hFF8000}};
    tbl[6]  = '{1, 17'h10005, 0, 4'd0, 24'h0,      25'h0};
    tbl[7]  = '{0, 17'h00000, 0, 4'd0, 24'h0,      {1'b1, 24'h123456}};
    tbl[8]  = '{0, 17'h00000, 0, 4'd0, 24'h0,      25'h0};
    tbl[9]  = '{0, 17'h00000, 1, 4'd5, 24'h00FF00, {1'b1, 24'hFF8000}};
    tbl[10] = '{1, 17'h00015, 0, 4'd0, 24'h0,      25'h0};
    tbl[11] = '{0, 17'h00000, 0, 4'd0, 24'h0,      25'h0};
    tbl[12] = '{0, 17'h00000, 0, 4'd0, 24'h0,      25'h0};
    tbl[13] = '{0, 17'h00000, 0, 4'd0, 24'h0,      {1'b1, 24'h00FF00}};
    tbl[14] = '{0, 17'h00000, 0, 4'd0, 24'h0,      25'h0};

    #1;
    do_reset();
    idle(4, 0);

`ifdef TITLE_FADE_EN
    idle(64, 1);
`endif

    // directed vectors: output for record r comes from record r-3
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].t, tbl[i].a, tbl[i].we, tbl[i].wi, tbl[i].wd, 0, 0);
      chk($sformatf("vec%0d", i), {7'd0, pix_valid, Red, Green, Blue}, {7'd0, tbl[i].exp_pix});
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 17'($urandom), $urandom_range(0, 3) == 0,
            4'($urandom), 24'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
    end
    idle(4, 0);

`ifdef TITLE_FADE_EN
    // fade progression, HOLD, restart priority
    do_reset();
    cycle(0, 17'd0, 1, 4'd1, 24'hFFFFFF, 0, 0);
    idle(8, 1);
    chk("lvl_after_8", {27'd0, fade_level}, 32'd2);
    cycle(1, 17'h00001, 0, 4'd0, 24'd0, 0, 0);
    idle(3, 0);
    chk("fade_pix", {7'd0, pix_valid, Red, Green, Blue}, {7'd0, 1'b1, 24'h1F1F1F});
    idle(55, 1);
    chk("pre_hold_state", {30'd0, fade_state}, 32'd1);
    idle(1, 1);
    chk("hold_state", {30'd0, fade_state}, 32'd2);
    chk("hold_level", {27'd0, fade_level}, 32'd16);
    idle(3, 1);
    chk("hold_stays", {27'd0, fade_level}, 32'd16);
    cycle(0, 17'd0, 0, 4'd0, 24'd0, 1, 1);
    chk("restart_level", {27'd0, fade_level}, 32'd0);
    chk("restart_state", {30'd0, fade_state}, 32'd1);
    idle(3, 1);
    chk("restart_cnt0", {27'd0, fade_level}, 32'd0);
    idle(1, 1);
    chk("restart_lvl1", {27'd0, fade_level}, 32'd1);
`endif

    // reset with pixels in flight
    do_reset();
`ifdef TITLE_FADE_EN
    idle(36, 1);
    chk("lvl9", {27'd0, fade_level}, 32'd9);
`endif
    cycle(0, 17'd0, 1, 4'd7, 24'hFFFFFF, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 17'h00007, 0, 4'd0, 24'd0, 0, 0);
    chk("inflight_opaque", {31'd0, pix_valid}, 32'd1);
    #2;
    do_reset();
    cycle(0, 17'd0, 0, 4'd0, 24'd0, 0, 0);
    chk("post_rst_pixel", {7'd0, pix_valid, Red, Green, Blue}, 32'd0);
    cycle(1, 17'h00007, 0, 4'd0, 24'd0, 0, 0);
    idle(3, 0);
    chk("pal_cleared", {7'd0, pix_valid, Red, Green, Blue}, {7'd0, 1'b1, 24'h000000});
    idle(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
